alarm_ring_ctrl: RTL and testbench
==================================

ALARM_RING_CTRL -- requirements
Module: alarm_ring_ctrl

Interface
REQ-001 Parameter RING_SEC, default 60, the ring duration in seconds before auto-off.
REQ-002 Parameter SNOOZE_MIN, default 5, the snooze interval in minutes.
REQ-003 Parameter MAX_SNOOZE, default 3, the maximum snoozes per alarm event (1..3).
REQ-004 Port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port tick_1hz, input, 1 bit: one-cycle pulse once per second, synchronous to clk.
REQ-007 Port hour, input, 8 bits: current time hour, packed BCD 00..23.
REQ-008 Port min, input, 8 bits: current time minute, packed BCD 00..59.
REQ-009 Port sec, input, 8 bits: current time second, packed BCD 00..59.
REQ-010 Port ahour, input, 8 bits: alarm hour, packed BCD.
REQ-011 Port amin, input, 8 bits: alarm minute, packed BCD.
REQ-012 Port alarm_en, input, 1 bit: alarm enable switch (level).
REQ-013 Port btn_snooze, input, 1 bit: debounced one-cycle snooze pulse.
REQ-014 Port btn_stop, input, 1 bit: debounced one-cycle stop pulse.
REQ-015 Port buzzer, output, 1 bit: buzzer drive.
REQ-016 Port ringing, output, 1 bit: high while in RING.
REQ-017 Port snoozing, output, 1 bit: high while in SNOOZE.
REQ-018 Port snooze_left, output, 2 bits: snoozes remaining in the current event.

Function
REQ-019 The FSM SHALL have three states: IDLE, RING and SNOOZE; all outputs SHALL be registered.
REQ-020 The alarm SHALL be armed only when alarm_en=1 and {ahour,amin} is not 16'h0000 (the all-zero alarm time means "not set").
REQ-021 In IDLE while armed, a cycle with tick_1hz=1, hour==ahour, min==amin and sec==8'h00 SHALL move the FSM to RING on the next edge, clear ring_cnt, and load snooze_left=MAX_SNOOZE.
REQ-022 In RING, ring_cnt SHALL increment on each tick_1hz.
REQ-023 In RING, buzzer SHALL be 1 while ring_cnt[0]==0 and 0 otherwise (1 s on / 1 s off); buzzer SHALL be 1 in the first cycle of RING.
REQ-024 RING SHALL go to IDLE on btn_stop, on alarm_en=0, or on the tick that makes ring_cnt reach RING_SEC.
REQ-025 RING SHALL go to SNOOZE on btn_snooze when snooze_left>0; on that transition snooze_left decrements and snz_cnt loads SNOOZE_MIN*60.
REQ-026 btn_snooze with snooze_left==0 SHALL be ignored, and ringing SHALL continue.
REQ-027 In SNOOZE, snz_cnt SHALL decrement on each tick_1hz.
REQ-028 In SNOOZE, the tick at which snz_cnt==1 SHALL move the FSM to RING with ring_cnt cleared; snooze_left SHALL be kept.
REQ-029 SNOOZE SHALL go to IDLE on btn_stop or alarm_en=0; btn_snooze SHALL be ignored in SNOOZE.
REQ-030 Simultaneous btn_stop and btn_snooze SHALL resolve as stop.
REQ-031 alarm_en=0 SHALL have priority over both buttons and over timer expiry.
REQ-032 A button pulse coincident with a tick SHALL take priority over tick-driven transitions.
REQ-033 Changes to ahour/amin while in RING or SNOOZE SHALL NOT affect the current event; they take effect from the next IDLE.
REQ-034 The time match SHALL be evaluated only in IDLE, so that auto-off at sec 00 of the following minute cannot re-trigger.
REQ-035 In IDLE and SNOOZE, buzzer SHALL be 0.
REQ-036 ring_cnt and snz_cnt SHALL be sized as minimal unsigned binary counters holding RING_SEC and SNOOZE_MIN*60 respectively.
REQ-037 tick_1hz asserted for longer than one cycle is outside the contract.

Reset
REQ-038 Asserting rst SHALL immediately force IDLE with buzzer=0, ringing=0, snoozing=0, snooze_left=0 and all counters 0, including mid-RING or mid-SNOOZE.
REQ-039 After rst deasserts, the first match SHALL require a fresh sec==00 tick.

Verification
REQ-040 Scenario: ahour=07, amin=30, alarm_en=1, time 07:29:59 then tick to 07:30:00 -> ringing=1 next cycle, buzzer toggles each tick, auto-off to IDLE after 60 ticks, and no re-ring at 07:31:00.
REQ-041 Scenario: RING, then btn_snooze -> snoozing=1, snooze_left=2; after 300 ticks -> ringing=1; snooze three times -> the fourth btn_snooze is ignored with snooze_left=0.
REQ-042 Scenario: btn_stop and btn_snooze in the same cycle during RING -> IDLE with snoozing=0.
REQ-043 Scenario: alarm time 00:00 with alarm_en=1 at time 00:00:00 -> no ring; alarm_en=0 during SNOOZE -> IDLE.
REQ-044 Scenario: rst pulse mid-RING, asynchronous to clk -> all outputs 0 within the reset assertion, and no ring until the next matching minute.

Source files
------------

// File: rtl/alarm_ring_ctrl.sv
// alarm_ring_ctrl
// Alarm clock ring controller. It watches the current BCD time against the
// alarm time and, at second 00 of the matching minute, starts ringing. The
// buzzer pulses 1 s on / 1 s off, the ring stops by itself after RING_SEC
// seconds, and up to MAX_SNOOZE snoozes of SNOOZE_MIN minutes each are allowed
// per alarm event.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   tick_1hz     one-cycle pulse per second
//   hour/min/sec current time, packed BCD
//   ahour/amin   alarm time, packed BCD (00:00 means "not set")
//   alarm_en     alarm enable switch (level)
//   btn_snooze   one-cycle snooze pulse
//   btn_stop     one-cycle stop pulse
//   buzzer       buzzer drive
//   ringing      high while ringing
//   snoozing     high while snoozing
//   snooze_left  snoozes remaining in the current event
module alarm_ring_ctrl #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic [7:0] hour,
  input  logic [7:0] min,
  input  logic [7:0] sec,
  input  logic [7:0] ahour,
  input  logic [7:0] amin,
  input  logic       alarm_en,
  input  logic       btn_snooze,
  input  logic       btn_stop,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [1:0] snooze_left
);

  localparam int SNZ_TOTAL = SNOOZE_MIN * 60;
  localparam int RW        = $clog2(RING_SEC + 1);
  localparam int SW        = $clog2(SNZ_TOTAL + 1);

  // A tick that arrives while ring_cnt already equals RING_SEC-1 is the one
  // that makes the count reach RING_SEC, so compare against that value.
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SEC - 1);
  localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNZ_TOTAL);
  localparam logic [1:0]    SNZ_MAX   = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [SW-1:0] snz_cnt_q, snz_cnt_d;
  logic [1:0]    snooze_left_q, snooze_left_d;
  logic          buzzer_q, buzzer_d;
  logic          ringing_q, ringing_d;
  logic          snoozing_q, snoozing_d;

  logic armed;
  logic time_match;

  always_comb begin
    armed      = alarm_en && ({ahour, amin} != 16'h0000);
    time_match = tick_1hz && (hour == ahour) && (min == amin) && (sec == 8'h00);

    state_d       = state_q;
    ring_cnt_d    = ring_cnt_q;
    snz_cnt_d     = snz_cnt_q;
    snooze_left_d = snooze_left_q;

    case (state_q)
      IDLE: begin
        ring_cnt_d    = '0;
        snz_cnt_d     = '0;
        snooze_left_d = 2'd0;
        // The match is looked at only here, so the auto-off tick at second 00
        // of the next minute can never start a new event.
        if (armed && time_match) begin
          state_d       = RING;
          snooze_left_d = SNZ_MAX;
        end
      end

      RING: begin
        // Priority: enable switch, then stop, then snooze, then the timer.
        if (!alarm_en || btn_stop) begin
          state_d       = IDLE;
          ring_cnt_d    = '0;
          snooze_left_d = 2'd0;
        end else if (btn_snooze && (snooze_left_q != 2'd0)) begin
          state_d       = SNOOZE;
          ring_cnt_d    = '0;
          snz_cnt_d     = SNZ_LOAD;
          snooze_left_d = snooze_left_q - 2'd1;
        end else if (tick_1hz) begin
          if (ring_cnt_q == RING_LAST) begin
            state_d       = IDLE;
            ring_cnt_d    = '0;
            snooze_left_d = 2'd0;
          end else begin
            ring_cnt_d = ring_cnt_q + RW'(1);
          end
        end
      end

      SNOOZE: begin
        // btn_snooze has no effect while already snoozing.
        if (!alarm_en || btn_stop) begin
          state_d       = IDLE;
          snz_cnt_d     = '0;
          snooze_left_d = 2'd0;
        end else if (tick_1hz) begin
          if (snz_cnt_q == SW'(1)) begin
            state_d    = RING;
            ring_cnt_d = '0;
            snz_cnt_d  = '0;
          end else begin
            snz_cnt_d = snz_cnt_q - SW'(1);
          end
        end
      end

      default: begin
        state_d       = IDLE;
        ring_cnt_d    = '0;
        snz_cnt_d     = '0;
        snooze_left_d = 2'd0;
      end
    endcase

    // Outputs are derived from the next state so they line up with it once
    // registered; ring_cnt is 0 on RING entry, so the buzzer starts on.
    ringing_d  = (state_d == RING);
    snoozing_d = (state_d == SNOOZE);
    buzzer_d   = (state_d == RING) && !ring_cnt_d[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ring_cnt_q    <= '0;
      snz_cnt_q     <= '0;
      snooze_left_q <= 2'd0;
      buzzer_q      <= 1'b0;
      ringing_q     <= 1'b0;
      snoozing_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ring_cnt_q    <= ring_cnt_d;
      snz_cnt_q     <= snz_cnt_d;
      snooze_left_q <= snooze_left_d;
      buzzer_q      <= buzzer_d;
      ringing_q     <= ringing_d;
      snoozing_q    <= snoozing_d;
    end
  end

  assign buzzer      = buzzer_q;
  assign ringing     = ringing_q;
  assign snoozing    = snoozing_q;
  assign snooze_left = snooze_left_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// tb_alarm_ring_ctrl
// Directed bench for alarm_ring_ctrl. Time is kept as seconds-of-day and an
// event-level model (mode, seconds rung, ticks until re-ring, snoozes left)
// predicts the outputs; a compare process checks them on every falling edge,
// and literal checks at key points pin the model.
module tb_alarm_ring_ctrl;

  localparam int RING_SEC   = 60;
  localparam int SNOOZE_MIN = 5;
  localparam int MAX_SNOOZE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic [7:0] hour = '0, min = '0, sec = '0, ahour = '0, amin = '0;
  logic       alarm_en = 1'b0;
  logic       btn_snooze = 1'b0, btn_stop = 1'b0;
  logic       buzzer, ringing, snoozing;
  logic [1:0] snooze_left;

  alarm_ring_ctrl #(
    .RING_SEC(RING_SEC), .SNOOZE_MIN(SNOOZE_MIN), .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
    .hour(hour), .min(min), .sec(sec), .ahour(ahour), .amin(amin),
    .alarm_en(alarm_en), .btn_snooze(btn_snooze), .btn_stop(btn_stop),
    .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing),
    .snooze_left(snooze_left)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Bench-side view of time and alarm in plain integers.
  int t_now;     // seconds of day
  int al_h, al_m;

  // Event-level model: 0 = quiet, 1 = ringing, 2 = snoozing.
  int m_mode, m_rung, m_wait, m_left;

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    chk(nm, act, exp);
    $display("check %s: got %0d want %0d", nm, act, exp);
  endtask

  task automatic model_reset();
    m_mode = 0; m_rung = 0; m_wait = 0; m_left = 0;
  endtask

  // One clock edge of the model, using the inputs held across that edge.
  task automatic model_step();
    bit armed, hit;
    armed = alarm_en && !(al_h == 0 && al_m == 0);
    hit   = tick_1hz && (t_now / 3600 == al_h) && ((t_now / 60) % 60 == al_m)
            && (t_now % 60 == 0);
    case (m_mode)
      0: if (armed && hit) begin m_mode = 1; m_rung = 0; m_left = MAX_SNOOZE; end
      1: begin
        if (!alarm_en || btn_stop) begin m_mode = 0; m_left = 0; end
        else if (btn_snooze && m_left > 0) begin
          m_mode = 2; m_left--; m_wait = SNOOZE_MIN * 60;
        end else if (tick_1hz) begin
          m_rung++;
          if (m_rung == RING_SEC) begin m_mode = 0; m_left = 0; end
        end
      end
      default: begin
        if (!alarm_en || btn_stop) begin m_mode = 0; m_left = 0; end
        else if (tick_1hz) begin
          m_wait--;
          if (m_wait == 0) begin m_mode = 1; m_rung = 0; end
        end
      end
    endcase
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("ringing",     int'(ringing),     int'(m_mode == 1));
      chk("snoozing",    int'(snoozing),    int'(m_mode == 2));
      chk("buzzer",      int'(buzzer),      int'(m_mode == 1 && (m_rung % 2) == 0));
      chk("snooze_left", int'(snooze_left), m_left);
    end
  end

  task automatic cyc(input bit tk, input bit sz, input bit sp);
    @(negedge clk);
    if (tk) t_now = (t_now + 1) % 86400;
    hour = bcd(t_now / 3600); min = bcd((t_now / 60) % 60); sec = bcd(t_now % 60);
    tick_1hz = tk; btn_snooze = sz; btn_stop = sp;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // One second: a tick cycle followed by a quiet cycle.
  task automatic sec1(input bit sz, input bit sp);
    cyc(1'b1, sz, sp);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic secs(input int n);
    for (int i = 0; i < n; i++) sec1(1'b0, 1'b0);
  endtask

  task automatic set_alarm(input int h, input int m);
    al_h = h; al_m = m; ahour = bcd(h); amin = bcd(m);
  endtask

  // Park the clock at 07:29:59 and tick into 07:30:00.
  task automatic ring_now();
    t_now = 7 * 3600 + 29 * 60 + 59;
    cyc(1'b0, 1'b0, 1'b0);
    sec1(1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    set_alarm(7, 30);
    alarm_en = 1'b1;
    t_now = 7 * 3600 + 29 * 60 + 58;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    lit("reset ringing", int'(ringing), 0);
    lit("reset snooze_left", int'(snooze_left), 0);
    @(negedge clk); #2 rst = 1'b0;

    // Ring at 07:30:00, toggle, auto-off after 60 s, no re-ring at 07:31:00.
    sec1(1'b0, 1'b0);
    lit("no ring 07:29:59", int'(ringing), 0);
    sec1(1'b0, 1'b0);
    lit("ring at 07:30:00", int'(ringing), 1);
    lit("buzzer first sec", int'(buzzer), 1);
    lit("snooze_left load", int'(snooze_left), 3);
    sec1(1'b0, 1'b0);
    lit("buzzer second sec", int'(buzzer), 0);
    secs(58);
    lit("still ring 59 ticks", int'(ringing), 1);
    sec1(1'b0, 1'b0);
    lit("auto-off 60 ticks", int'(ringing), 0);
    lit("auto-off time sec", t_now % 60, 0);
    secs(3);
    lit("no re-ring 07:31", int'(ringing), 0);

    // Snooze chain: three snoozes then the fourth request is ignored.
    ring_now();
    cyc(1'b0, 1'b1, 1'b0);
    lit("snooze 1 snoozing", int'(snoozing), 1);
    lit("snooze 1 left", int'(snooze_left), 2);
    secs(299);
    lit("snooze 299 ticks", int'(snoozing), 1);
    sec1(1'b0, 1'b0);
    lit("re-ring 300 ticks", int'(ringing), 1);
    lit("re-ring buzzer", int'(buzzer), 1);
    cyc(1'b1, 1'b1, 1'b0);            // snooze coincident with a tick
    lit("snooze 2 left", int'(snooze_left), 1);
    sec1(1'b1, 1'b0);                 // snooze in SNOOZE is ignored
    lit("snooze in snooze", int'(snooze_left), 1);
    secs(299);
    cyc(1'b0, 1'b1, 1'b0);
    lit("snooze 3 left", int'(snooze_left), 0);
    secs(300);
    lit("third re-ring", int'(ringing), 1);
    cyc(1'b0, 1'b1, 1'b0);
    lit("4th snooze ignored", int'(ringing), 1);
    lit("4th snooze left", int'(snooze_left), 0);
    cyc(1'b0, 1'b0, 1'b1);
    lit("stop after chain", int'(ringing), 0);

    // Stop and snooze together resolve as stop.
    ring_now();
    cyc(1'b0, 1'b1, 1'b1);
    lit("stop+snooze ringing", int'(ringing), 0);
    lit("stop+snooze snoozing", int'(snoozing), 0);

    // alarm_en=0 during snooze; alarm changes mid-event are irrelevant.
    ring_now();
    cyc(1'b0, 1'b1, 1'b0);
    set_alarm(7, 31);
    secs(5);
    alarm_en = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    lit("en=0 in snooze", int'(snoozing), 0);
    alarm_en = 1'b1;
    set_alarm(7, 30);

    // Unset alarm time 00:00 never rings.
    set_alarm(0, 0);
    t_now = 86399;
    cyc(1'b0, 1'b0, 1'b0);
    sec1(1'b0, 1'b0);
    lit("00:00 not set", int'(ringing), 0);
    set_alarm(7, 30);

    // Asynchronous reset mid-ring.
    ring_now();
    secs(3);
    #2 rst = 1'b1;
    #1;
    lit("rst buzzer", int'(buzzer), 0);
    lit("rst ringing", int'(ringing), 1 - 1 + int'(1'b0));
    lit("rst snooze_left", int'(snooze_left), 0);
    model_reset();
    @(negedge clk); #2 rst = 1'b0;
    secs(5);
    lit("no ring after rst", int'(ringing), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
